// File: rtl/logic_gate_sweep.sv
// logic_gate_sweep: N-input logic gate with a registered output, a selectable
// gate function, a single-beat external operand port and a built-in exhaustive
// truth-table sweep that counts the 1-results as a signature.
module logic_gate_sweep #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   mode,
    input  logic         start,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    output logic         in_ready,
    output logic         y_valid,
    output logic         y,
    output logic [N-1:0] y_vec,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Terminal sweep value 2^N-1; cnt carries one spare bit so it never wraps.
    localparam logic [N:0] CNT_LAST = {1'b0, {N{1'b1}}};

    // Reduction gate over all N operand bits; reserved selects give 0.
    function automatic logic gate_f(input logic [2:0] sel, input logic [N-1:0] v);
        logic r;
        case (sel)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ^v;
            3'd3:    r = ~&v;
            3'd4:    r = ~|v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0] state_r;
    logic [N:0] cnt_r;
    logic [2:0] mode_q_r;
    logic       y_r;
    logic [N-1:0] y_vec_r;
    logic       y_valid_r;
    logic       done_r;
    logic [N:0] ones_count_r;

    logic       ext_res_s;
    logic       sweep_res_s;

    // Gate results for the external operand (live mode) and the sweep vector (latched mode).
    always_comb begin
        ext_res_s   = gate_f(mode, in_a);
        sweep_res_s = gate_f(mode_q_r, cnt_r[N-1:0]);
    end

    // A sweep request in IDLE takes priority over an external operand.
    assign in_ready   = (state_r == S_IDLE) && !start;
    assign busy       = (state_r != S_IDLE);
    assign y          = y_r;
    assign y_vec      = y_vec_r;
    assign y_valid    = y_valid_r;
    assign done       = done_r;
    assign ones_count = ones_count_r;

    // Sequencer, result registers and 1-result signature counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= '0;
            mode_q_r     <= 3'd0;
            y_r          <= 1'b0;
            y_vec_r      <= '0;
            y_valid_r    <= 1'b0;
            done_r       <= 1'b0;
            ones_count_r <= '0;
        end else begin
            y_valid_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r      <= S_SWEEP;
                        cnt_r        <= '0;
                        ones_count_r <= '0;
                        mode_q_r     <= mode;
                    end else if (in_valid) begin
                        y_r       <= ext_res_s;
                        y_vec_r   <= in_a;
                        y_valid_r <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    y_r          <= sweep_res_s;
                    y_vec_r      <= cnt_r[N-1:0];
                    y_valid_r    <= 1'b1;
                    ones_count_r <= ones_count_r + {{N{1'b0}}, sweep_res_s};
                    cnt_r        <= cnt_r + {{N{1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Directed self-checking bench for logic_gate_sweep with N=2, 3 and 4 instances.
module tb_logic_gate_sweep;

    logic clk;
    logic rst_n;

    logic [2:0] m2, m3, m4;
    logic       st2, st3, st4;
    logic       iv2, iv3, iv4;
    logic [1:0] a2;
    logic [2:0] a3;
    logic [3:0] a4;
    logic       rdy2, rdy3, rdy4;
    logic       yv2, yv3, yv4;
    logic       y2, y3, y4;
    logic [1:0] yvec2;
    logic [2:0] yvec3;
    logic [3:0] yvec4;
    logic       busy2, busy3, busy4;
    logic       done2, done3, done4;
    logic [2:0] oc2;
    logic [3:0] oc3;
    logic [4:0] oc4;

    int n_cmp = 0;
    int n_err = 0;

    logic_gate_sweep #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n), .mode(m2), .start(st2), .in_valid(iv2), .in_a(a2),
        .in_ready(rdy2), .y_valid(yv2), .y(y2), .y_vec(yvec2), .busy(busy2),
        .done(done2), .ones_count(oc2)
    );
    logic_gate_sweep #(.N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .mode(m3), .start(st3), .in_valid(iv3), .in_a(a3),
        .in_ready(rdy3), .y_valid(yv3), .y(y3), .y_vec(yvec3), .busy(busy3),
        .done(done3), .ones_count(oc3)
    );
    logic_gate_sweep #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .mode(m4), .start(st4), .in_valid(iv4), .in_a(a4),
        .in_ready(rdy4), .y_valid(yv4), .y(y4), .y_vec(yvec4), .busy(busy4),
        .done(done4), .ones_count(oc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // N=2 sweep; the previous y_vec is always 3 when this is called.
    task automatic sweep2(input logic [2:0] md, input logic [3:0] pat, input int ones);
        m2 = md; st2 = 1'b1; #1;
        chk("s2 rdy at start", 32'(rdy2), 32'd0);
        @(posedge clk); #1; st2 = 1'b0;
        chk("s2 no echo yv", 32'(yv2), 32'd0);
        chk("s2 no echo vec", 32'(yvec2), 32'd3);
        chk("s2 busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2 rdy %0d", i), 32'(rdy2), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("s2 yv %0d", i), 32'(yv2), 32'd1);
            chk($sformatf("s2 vec %0d", i), 32'(yvec2), 32'(i));
            chk($sformatf("s2 y %0d", i), 32'(y2), 32'(pat[i]));
            chk($sformatf("s2 done %0d", i), 32'(done2), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("s2 ones", 32'(oc2), 32'(ones));
        chk("s2 rdy in done", 32'(rdy2), 32'd0);
        chk("s2 busy in done", 32'(busy2), 32'd1);
        @(posedge clk); #1;
        chk("s2 done drop", 32'(done2), 32'd0);
        chk("s2 yv after", 32'(yv2), 32'd0);
        chk("s2 busy after", 32'(busy2), 32'd0);
        chk("s2 rdy after", 32'(rdy2), 32'd1);
        chk("s2 ones hold", 32'(oc2), 32'(ones));
    endtask

    // N=3 sweep; mode is changed to md_late after the second result.
    task automatic sweep3(input logic [2:0] md, input logic [2:0] md_late,
                          input logic [7:0] pat, input int ones);
        m3 = md; st3 = 1'b1;
        @(posedge clk); #1; st3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) m3 = md_late;
            chk($sformatf("s3 yv %0d", i), 32'(yv3), 32'd1);
            chk($sformatf("s3 vec %0d", i), 32'(yvec3), 32'(i));
            chk($sformatf("s3 y %0d", i), 32'(y3), 32'(pat[i]));
            chk($sformatf("s3 done %0d", i), 32'(done3), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("s3 ones", 32'(oc3), 32'(ones));
        @(posedge clk); #1;
        chk("s3 idle", 32'(busy3), 32'd0);
    endtask

    // N=4 sweep with per-beat checks.
    task automatic sweep4(input logic [2:0] md, input logic [15:0] pat, input int ones);
        m4 = md; st4 = 1'b1;
        @(posedge clk); #1; st4 = 1'b0;
        chk("s4 busy", 32'(busy4), 32'd1);
        chk("s4 yv at start", 32'(yv4), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk($sformatf("s4 yv %0d", i), 32'(yv4), 32'd1);
            chk($sformatf("s4 vec %0d", i), 32'(yvec4), 32'(i));
            chk($sformatf("s4 y %0d", i), 32'(y4), 32'(pat[i]));
            chk($sformatf("s4 done %0d", i), 32'(done4), (i == 15) ? 32'd1 : 32'd0);
        end
        chk("s4 ones", 32'(oc4), 32'(ones));
        @(posedge clk); #1;
        chk("s4 done drop", 32'(done4), 32'd0);
        chk("s4 yv after", 32'(yv4), 32'd0);
        chk("s4 idle", 32'(busy4), 32'd0);
    endtask

    initial begin
        logic [3:0] and2_exp;
        and2_exp = 4'b1000;
        m2 = 3'd0; m3 = 3'd0; m4 = 3'd0;
        st2 = 1'b0; st3 = 1'b0; st4 = 1'b0;
        iv2 = 1'b0; iv3 = 1'b0; iv4 = 1'b0;
        a2 = '0; a3 = '0; a4 = '0;
        rst_n = 1'b0;
        #3;
        chk("rst yv", 32'(yv2), 32'd0);
        chk("rst y", 32'(y4), 32'd0);
        chk("rst vec", 32'(yvec3), 32'd0);
        chk("rst busy", 32'(busy4), 32'd0);
        chk("rst done", 32'(done2), 32'd0);
        chk("rst ones", 32'(oc4), 32'd0);
        chk("rst rdy", 32'(rdy2), 32'd1);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;

        // External AND, N=2, back-to-back operands.
        m2 = 3'd0; iv2 = 1'b1; a2 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ext rdy %0d", i), 32'(rdy2), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("ext yv %0d", i), 32'(yv2), 32'd1);
            chk($sformatf("ext y %0d", i), 32'(y2), 32'(and2_exp[i]));
            chk($sformatf("ext vec %0d", i), 32'(yvec2), 32'(i));
            if (i < 3) a2 = 2'(i + 1);
            else iv2 = 1'b0;
        end
        @(posedge clk); #1;
        chk("ext idle yv", 32'(yv2), 32'd0);
        chk("ext hold y", 32'(y2), 32'd1);

        // start and in_valid together: sweep wins, in_valid ignored during sweep.
        iv2 = 1'b1; a2 = 2'b01;
        sweep2(3'd0, 4'b1000, 1);
        iv2 = 1'b0;

        // Reserved mode on the external path and a sweep.
        m2 = 3'd6; iv2 = 1'b1; a2 = 2'b11;
        @(posedge clk); #1; iv2 = 1'b0;
        chk("rsv ext yv", 32'(yv2), 32'd1);
        chk("rsv ext y", 32'(y2), 32'd0);
        chk("rsv ext vec", 32'(yvec2), 32'd3);
        sweep2(3'd6, 4'b0000, 0);

        // N=4 sweeps: AND, OR, XOR.
        sweep4(3'd0, 16'h8000, 1);
        sweep4(3'd1, 16'hFFFE, 15);
        sweep4(3'd2, 16'h6996, 8);

        // Mode latch: NAND sweep with mode switched to AND mid-sweep.
        sweep3(3'd3, 3'd0, 8'h7F, 7);

        // Reset mid-sweep at the 5th result.
        m3 = 3'd1; st3 = 1'b1;
        @(posedge clk); #1; st3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("mid vec before rst", 32'(yvec3), 32'd4);
        chk("mid ones before rst", 32'(oc3), 32'd4);
        rst_n = 1'b0; #1;
        chk("mid rst yv", 32'(yv3), 32'd0);
        chk("mid rst y", 32'(y3), 32'd0);
        chk("mid rst vec", 32'(yvec3), 32'd0);
        chk("mid rst busy", 32'(busy3), 32'd0);
        chk("mid rst ones", 32'(oc3), 32'd0);
        chk("mid rst done", 32'(done3), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid no done %0d", i), 32'(done3), 32'd0);
            chk($sformatf("mid no yv %0d", i), 32'(yv3), 32'd0);
        end
        sweep3(3'd1, 3'd1, 8'hFE, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logic_gate_sweep.md
# logic_gate_sweep

Parametrised N-input logic gate unit with a registered output, a selectable gate function and a built-in exhaustive truth-table sweep. Operands come either from an external single-beat valid/ready port or from an internal sweep that applies every input combination 0..2^N-1 in order. Each sweep also produces a count of 1-results as a pass/fail signature. The block sits in the basic-gates library as the multi-input, multi-mode successor of the two-input gates, and is usable both as a datapath gate and as a self-test source.

## Interface
- N, default 2: gate input count; legal range 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  3  gate select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are reserved and produce y=0.
- start  in  1  sweep request; sampled only in IDLE.
- in_valid  in  1  external operand valid.
- in_a  in  N  external operand vector; bit i is gate input i.
- in_ready  out  1  external operand accepted this cycle.
- y_valid  out  1  y and y_vec carry a new result this cycle.
- y  out  1  gate result, registered.
- y_vec  out  N  operand that produced y.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at sweep completion.
- ones_count  out  N+1  number of y=1 results in the last sweep.

## Operation
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when start=1. On that edge, cnt is set to 0, ones_count is cleared and the mode is latched into mode_q.
  - SWEEP -> DONE on the edge that processes cnt = 2^N-1.
  - DONE -> IDLE unconditionally on the next edge.
- in_ready = (state==IDLE) && !start. It is combinational.
- start and in_valid high together in IDLE: start wins and the operand is not accepted.
- External path: on an edge with in_valid && in_ready:
  - y = f(mode, in_a), y_vec = in_a, y_valid = 1.
  - ones_count is not modified.
- Sweep path: on every edge in SWEEP:
  - y = f(mode_q, cnt), y_vec = cnt, y_valid = 1.
  - ones_count += y.
  - cnt increments.
- A mode change during a sweep has no effect. The sweep always uses mode_q.
- On any edge without a new result, y_valid = 0. y and y_vec hold their previous values.
- f is a reduction over all N bits: &, |, ^, ~&, ~|, ~^.
- ones_count is N+1 bits, so the maximum value 2^N fits without wrap. It holds its value after DONE until the next start.
- start in SWEEP or DONE is ignored; there is no queuing or restart.
- cnt is N+1 bits internally. Wrap is never reached because the terminal test is cnt == 2^N-1.

## Timing
- Reset (asynchronous, rst_n=0):
  - state = IDLE, cnt = 0, mode_q = 0.
  - y_valid = 0, y = 0, y_vec = 0, done = 0, ones_count = 0, busy = 0.
  - in_ready follows its equation and is 1 if start=0.
- Reset mid-sweep aborts immediately. No done pulse is produced and ones_count reads 0.
- External latency: 1 cycle. An operand accepted at edge E appears with y_valid=1 after E. Throughput is one operand per cycle.
- Sweep timeline with E0 as the edge sampling start:
  - Results for vectors 0..2^N-1 appear after edges E1..E_{2^N}, one per cycle, with no gaps.
  - done = 1 and the final ones_count appear after E_{2^N}, in the same cycle as the last y_valid.
  - busy = 1 from after E0 through the DONE cycle.
  - in_ready rises after E_{2^N+1}.
- done is registered and never held for more than 1 cycle.

## Test plan
- Reset mid-sweep: N=3, assert rst_n=0 for 1 cycle at the 5th result. Required:
  - all outputs 0 asynchronously;
  - no done pulse;
  - a subsequent mode=1 sweep gives ones_count=7.
- External AND, N=2, mode=0, in_a driven 00, 01, 10, 11 on consecutive cycles with in_valid=1. Required:
  - y = 0, 0, 0, 1, each 1 cycle later;
  - y_vec echoes the input;
  - in_ready = 1 throughout.
- Sweep, N=4, in three separate runs. Required:
  - mode=0: 16 consecutive y_valid beats, y_vec = 0..15, ones_count=1, done after the 16th beat.
  - mode=1: ones_count=15.
  - mode=2: ones_count=8.
- Mode latch, N=3: start with mode=3 (NAND), switch mode to 0 after 2 cycles. Required: ones_count=7, with y=0 only at y_vec=7.
- start and in_valid high together in IDLE, N=2. Required:
  - in_ready=0 that cycle;
  - the operand is not echoed;
  - the sweep runs 4 beats;
  - in_valid during the sweep is ignored with in_ready=0.
- Reserved mode, N=2, mode=6: external in_a=11 and a sweep. Required: y=0 and ones_count=0.
